plic_lite: RTL and testbench

- Small platform-level interrupt arbiter for the RISC core.
- Collects NUM_SRC external interrupt lines, each through a per-source gateway with level or edge mode.
- Arbitrates pending sources by programmable priority against a threshold and drives o_meip into the machine trap controller.
- Software claims and completes interrupts through a simple register port: the trap handler reads the claim register to get an ID and writes the same register to complete.

---
 rtl/plic_pkg.sv | 17 +
 rtl/plic_gateway.sv | 63 ++++++
 rtl/plic_lite.sv | 146 ++++++++++++++
 tb/tb_plic_lite.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// plic_pkg: shared definitions for the plic_lite interrupt controller.
//   - Byte offsets of the configuration registers.
//   - Default claim-ID width and the matching ID type.
package plic_pkg;

  localparam int ID_W_DEF = 4;
  typedef logic [ID_W_DEF-1:0] plic_id_t;

  // Register byte offsets (32-bit words).
  localparam logic [7:0] PRIO_BASE = 8'h00;  // priority[s] at PRIO_BASE + 4*s
  localparam logic [7:0] ENABLE    = 8'h20;
  localparam logic [7:0] PENDING   = 8'h24;
  localparam logic [7:0] THRESH    = 8'h28;
  localparam logic [7:0] CLAIM     = 8'h2C;
  localparam logic [7:0] EDGE_MODE = 8'h30;

endpackage

// File: rtl/plic_gateway.sv
// plic_gateway: per-source interrupt gateway.
// Turns one raw interrupt line into a pending bit and tracks whether the
// source is currently being serviced by software.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_src            raw interrupt line (synchronous to i_clk)
//   i_edge_mode      1 = rising-edge triggered, 0 = level triggered
//   i_claim_clr      this source is being claimed this cycle
//   i_complete_clr   software completes this source this cycle
//   o_pending        pending bit
//   o_in_service     claimed and not yet completed
module plic_gateway (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_src,
  input  logic i_edge_mode,
  input  logic i_claim_clr,
  input  logic i_complete_clr,
  output logic o_pending,
  output logic o_in_service
);

  logic src_q, src_d;
  logic pending_q, pending_d;
  logic in_service_q, in_service_d;
  logic set;

  always_comb begin
    // Edge mode may set while in service, so one further edge is remembered.
    // Level mode is held off until the current request has been completed.
    if (i_edge_mode) begin
      set = i_src & ~src_q;
    end else begin
      set = i_src & ~pending_q & ~in_service_q & ~i_claim_clr;
    end
    src_d = i_src;
    // A set in the same cycle as a claim wins, so the new edge is not lost.
    pending_d    = (pending_q & ~i_claim_clr) | set;
    in_service_d = in_service_q;
    if (i_complete_clr) begin
      in_service_d = 1'b0;
    end
    if (i_claim_clr) begin
      in_service_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      src_q        <= 1'b0;
      pending_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      src_q        <= src_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  assign o_pending    = pending_q;
  assign o_in_service = in_service_q;

endmodule

// File: rtl/plic_lite.sv
// plic_lite: small platform-level interrupt controller.
// Gateways feed a priority arbiter; the winner above threshold raises o_meip.
// Software claims by reading CLAIM and completes by writing the ID back.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_irq_src              raw interrupt lines
//   i_cfg_we / i_cfg_re    register write / read strobes
//   i_cfg_addr/_wdata      byte address and write data
//   o_cfg_rdata/o_cfg_ack  registered read data and one-cycle acknowledge
//   o_meip                 registered interrupt request to the core
//   o_best_id              combinational arbitration winner (0 = none)
module plic_lite
  import plic_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SRC-1:0] i_irq_src,
  input  logic               i_cfg_we,
  input  logic               i_cfg_re,
  input  logic [7:0]         i_cfg_addr,
  input  logic [31:0]        i_cfg_wdata,
  output logic [31:0]        o_cfg_rdata,
  output logic               o_cfg_ack,
  output logic               o_meip,
  output logic [ID_W-1:0]    o_best_id
);

  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [PRIO_W-1:0]  prio_d [NUM_SRC];
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] edge_q, edge_d;
  logic [PRIO_W-1:0]  thresh_q, thresh_d;
  logic               ack_q, ack_d;
  logic               meip_q, meip_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [NUM_SRC-1:0] pending, in_service, claim_clr, complete_clr;
  logic [ID_W-1:0]    best_id;
  logic [PRIO_W-1:0]  best_prio;
  logic [5:0]         word;
  logic               wr_en, rd_en, claim_rd, complete_wr;
  logic [ID_W-1:0]    complete_id;
  logic               unused_wdata;

  assign word        = i_cfg_addr[7:2];
  assign wr_en       = i_cfg_we;
  // A simultaneous write takes precedence; the read side is dropped.
  assign rd_en       = i_cfg_re & ~i_cfg_we;
  assign claim_rd    = rd_en & (i_cfg_addr == CLAIM);
  assign complete_wr = wr_en & (i_cfg_addr == CLAIM);
  assign complete_id = i_cfg_wdata[ID_W-1:0];
  assign unused_wdata = ^i_cfg_wdata;

  // Arbiter: strict '>' keeps the lowest ID on equal priority.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (pending[s] && enable_q[s] && (prio_q[s] > thresh_q) && (prio_q[s] > best_prio)) begin
        best_prio = prio_q[s];
        best_id   = ID_W'(s + 1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign claim_clr[gi]    = claim_rd & (best_id == ID_W'(gi + 1));
    assign complete_clr[gi] = complete_wr & (complete_id == ID_W'(gi + 1)) & in_service[gi];

    plic_gateway u_gateway (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_src          (i_irq_src[gi]),
      .i_edge_mode    (edge_q[gi]),
      .i_claim_clr    (claim_clr[gi]),
      .i_complete_clr (complete_clr[gi]),
      .o_pending      (pending[gi]),
      .o_in_service   (in_service[gi])
    );
  end

  // Register file and read mux.
  always_comb begin
    prio_d   = prio_q;
    enable_d = enable_q;
    edge_d   = edge_q;
    thresh_d = thresh_q;
    rdata_d  = '0;
    if (wr_en) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (word == 6'(s)) prio_d[s] = i_cfg_wdata[PRIO_W-1:0];
      end
      case (i_cfg_addr)
        ENABLE:    enable_d = i_cfg_wdata[NUM_SRC-1:0];
        THRESH:    thresh_d = i_cfg_wdata[PRIO_W-1:0];
        EDGE_MODE: edge_d   = i_cfg_wdata[NUM_SRC-1:0];
        default:   ;
      endcase
    end
    if (rd_en) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (word == 6'(s)) rdata_d = 32'(prio_q[s]);
      end
      case (i_cfg_addr)
        ENABLE:    rdata_d = 32'(enable_q);
        PENDING:   rdata_d = 32'(pending);
        THRESH:    rdata_d = 32'(thresh_q);
        CLAIM:     rdata_d = 32'(best_id);
        EDGE_MODE: rdata_d = 32'(edge_q);
        default:   ;
      endcase
    end
    ack_d  = i_cfg_we | i_cfg_re;
    meip_d = (best_id != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < NUM_SRC; s++) prio_q[s] <= '0;
      enable_q <= '0;
      edge_q   <= '0;
      thresh_q <= '0;
      ack_q    <= 1'b0;
      meip_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      prio_q   <= prio_d;
      enable_q <= enable_d;
      edge_q   <= edge_d;
      thresh_q <= thresh_d;
      ack_q    <= ack_d;
      meip_q   <= meip_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_cfg_rdata = rdata_q;
  assign o_cfg_ack   = ack_q;
  assign o_meip      = meip_q;
  assign o_best_id   = best_id;

endmodule

// File: tb/tb_plic_lite.sv
// tb_plic_lite: self-checking bench for plic_lite.
// A behavioural model (per-source bit arrays, priority scan from the top
// level down) predicts best_id, meip, ack and rdata every cycle; directed
// scenarios add explicit checks, followed by a randomized phase.
module tb_plic_lite;
  import plic_pkg::*;

  localparam int NS = 8;
  localparam int PW = 3;
  localparam int IW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NS-1:0] src   = '0;
  logic          we    = 1'b0;
  logic          re    = 1'b0;
  logic [7:0]    addr  = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          ack, meip;
  logic [IW-1:0] best_id;

  always #5 clk = ~clk;

  plic_lite #(.NUM_SRC(NS), .PRIO_W(PW), .ID_W(IW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_irq_src   (src),
    .i_cfg_we    (we),
    .i_cfg_re    (re),
    .i_cfg_addr  (addr),
    .i_cfg_wdata (wdata),
    .o_cfg_rdata (rdata),
    .o_cfg_ack   (ack),
    .o_meip      (meip),
    .o_best_id   (best_id)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [PW-1:0] m_prio [NS];
  bit [NS-1:0] m_en, m_edge, m_pend, m_insvc, m_src_prev;
  bit [PW-1:0] m_thresh;
  bit          m_ack, m_meip;
  bit [31:0]   m_rdata;
  bit          l_we, l_re;
  bit [7:0]    l_addr;
  bit [31:0]   l_wdata;

  function automatic void model_clear();
    for (int s = 0; s < NS; s++) m_prio[s] = '0;
    m_en = '0; m_edge = '0; m_pend = '0; m_insvc = '0; m_src_prev = '0;
    m_thresh = '0; m_ack = 0; m_meip = 0; m_rdata = '0;
  endfunction

  // Highest priority level first; within a level, the first (lowest) ID.
  function automatic int model_best();
    for (int p = (1 << PW) - 1; p > int'(m_thresh); p--)
      for (int s = 0; s < NS; s++)
        if (m_pend[s] && m_en[s] && int'(m_prio[s]) == p) return s + 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a, input int best);
    if (int'(a) < 4 * NS) return 32'(m_prio[int'(a) / 4]);
    case (a)
      ENABLE:    return 32'(m_en);
      PENDING:   return 32'(m_pend);
      THRESH:    return 32'(m_thresh);
      CLAIM:     return 32'(best);
      EDGE_MODE: return 32'(m_edge);
      default:   return 32'h0;
    endcase
  endfunction

  // One clock cycle: check outputs against the model, then advance both.
  task automatic step();
    int            best, claim_id, comp_id;
    logic [31:0]   rd_next;
    bit   [NS-1:0] np, ni;
    bit            rise, set_b, claimed;
    #2;
    best = model_best();
    check_eq("best_id", 32'(best_id), 32'(best));
    check_eq("meip",    32'(meip),    32'(m_meip));
    check_eq("ack",     32'(ack),     32'(m_ack));
    check_eq("rdata",   rdata,        m_rdata);
    if (m_ack)
      $display("txn t=%0t we=%0d re=%0d addr=0x%02h wdata=0x%08h rdata=0x%08h",
               $time, l_we, l_re, l_addr, l_wdata, rdata);
    claim_id = (re && !we && addr == CLAIM) ? best : 0;
    comp_id  = (we && addr == CLAIM) ? int'(wdata[IW-1:0]) : 0;
    rd_next  = (re && !we) ? model_read(addr, best) : 32'h0;
    for (int s = 0; s < NS; s++) begin
      claimed = (claim_id == s + 1);
      rise    = src[s] && !m_src_prev[s];
      if (m_edge[s]) set_b = rise;
      else           set_b = src[s] && !m_pend[s] && !m_insvc[s] && !claimed;
      np[s] = (m_pend[s] && !claimed) || set_b;
      ni[s] = m_insvc[s];
      if (comp_id == s + 1) ni[s] = 1'b0;
      if (claimed) ni[s] = 1'b1;
    end
    @(posedge clk);
    m_pend = np;
    m_insvc = ni;
    if (we) begin
      if (int'(addr) < 4 * NS) m_prio[int'(addr) / 4] = wdata[PW-1:0];
      if (addr == ENABLE)    m_en     = wdata[NS-1:0];
      if (addr == THRESH)    m_thresh = wdata[PW-1:0];
      if (addr == EDGE_MODE) m_edge   = wdata[NS-1:0];
    end
    m_ack = we || re;
    m_rdata = rd_next;
    m_meip = (best != 0);
    m_src_prev = src;
    l_we = we; l_re = re; l_addr = addr; l_wdata = wdata;
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    re = 1'b1; addr = a;
    step();
    re = 1'b0;
    d = rdata;
  endtask

  // Asserts reset between clock edges and checks that outputs drop at once.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_ack",   32'(ack),     32'h0);
    check_eq("rst_rdata", rdata,        32'h0);
    check_eq("rst_meip",  32'(meip),    32'h0);
    check_eq("rst_best",  32'(best_id), 32'h0);
    model_clear();
    we = 1'b0; re = 1'b0; src = '0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_addr();
    int k;
    k = $urandom_range(0, 14);
    if (k < NS) return 8'(4 * k);
    case (k)
      8:  return ENABLE;
      9:  return PENDING;
      10: return THRESH;
      11: return CLAIM;
      12: return EDGE_MODE;
      13: return 8'h34;
      default: return 8'hFC;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    model_clear();
    @(posedge clk);
    #1;

    // ---- reset mid-operation ----
    apply_reset();
    wr(8'h04, 1); wr(ENABLE, 32'h02);
    src[1] = 1'b1; step(); step();
    rd(CLAIM, d);            check_eq("mid_claim", d, 32'd2);
    wr(8'h00, 2); wr(ENABLE, 32'h07);
    src[0] = 1'b1; src[2] = 1'b1; step();
    rd(PENDING, d);          check_eq("mid_pending", d, 32'h05);
    check_eq("mid_meip_before", 32'(meip), 32'h1);
    apply_reset();
    rd(PENDING, d);          check_eq("post_rst_pending", d, 32'h0);
    rd(ENABLE, d);           check_eq("post_rst_enable", d, 32'h0);

    // ---- level path ----
    apply_reset();
    wr(8'h08, 3); wr(ENABLE, 32'h04); wr(THRESH, 1);
    src[2] = 1'b1; step();
    check_eq("lvl_best_n1", 32'(best_id), 32'd3);
    check_eq("lvl_meip_n1", 32'(meip), 32'd0);
    step();
    check_eq("lvl_meip_n2", 32'(meip), 32'd1);
    rd(CLAIM, d);            check_eq("lvl_claim", d, 32'd3);
    check_eq("lvl_best_after_claim", 32'(best_id), 32'd0);
    step();
    check_eq("lvl_meip_drop", 32'(meip), 32'd0);
    wr(CLAIM, 3);
    check_eq("lvl_best_at_complete", 32'(best_id), 32'd0);
    step();
    check_eq("lvl_repend_best", 32'(best_id), 32'd3);
    rd(PENDING, d);          check_eq("lvl_repend", d, 32'h04);

    // ---- priority and tie ----
    apply_reset();
    wr(8'h04, 4); wr(8'h14, 4); wr(8'h0C, 6); wr(ENABLE, 32'h2A);
    src = 8'h2A; step(); step();
    rd(CLAIM, d);            check_eq("prio_claim1", d, 32'd4);
    rd(CLAIM, d);            check_eq("prio_claim2", d, 32'd2);
    rd(CLAIM, d);            check_eq("prio_claim3", d, 32'd6);
    rd(CLAIM, d);            check_eq("claim_none", d, 32'd0);
    rd(PENDING, d);          check_eq("claim_none_pend", d, 32'h0);
    wr(CLAIM, 4); wr(CLAIM, 2); wr(CLAIM, 6); step(); step();
    check_eq("prio_best_repend", 32'(best_id), 32'd4);
    wr(THRESH, 6);
    check_eq("thr_best", 32'(best_id), 32'd0);
    step();
    check_eq("thr_meip", 32'(meip), 32'd0);

    // ---- complete boundaries and we+re ----
    wr(THRESH, 0);
    rd(CLAIM, d);            check_eq("bnd_claim", d, 32'd4);
    wr(CLAIM, 0); wr(CLAIM, 9); wr(CLAIM, 2); step();
    rd(PENDING, d);          check_eq("bnd_pending", d, 32'h22);
    we = 1'b1; re = 1'b1; addr = CLAIM; wdata = 32'd4;
    step();
    we = 1'b0; re = 1'b0;
    check_eq("wr_rd_ack", 32'(ack), 32'd1);
    check_eq("wr_rd_rdata", rdata, 32'd0);
    step();
    check_eq("wr_rd_single_ack", 32'(ack), 32'd0);
    step();
    rd(PENDING, d);          check_eq("wr_rd_complete", d, 32'h2A);

    // ---- edge mode ----
    apply_reset();
    wr(EDGE_MODE, 1); wr(8'h00, 1); wr(ENABLE, 1);
    src[0] = 1'b1; step(); src[0] = 1'b0; step();
    check_eq("edge_best", 32'(best_id), 32'd1);
    rd(CLAIM, d);            check_eq("edge_claim1", d, 32'd1);
    src[0] = 1'b1; step(); src[0] = 1'b0; step();
    rd(PENDING, d);          check_eq("edge_repend_insvc", d, 32'h01);
    src[0] = 1'b1; step(); src[0] = 1'b0; step();
    rd(PENDING, d);          check_eq("edge_third", d, 32'h01);
    rd(CLAIM, d);            check_eq("edge_claim2", d, 32'd1);
    rd(PENDING, d);          check_eq("edge_single", d, 32'h0);

    // ---- claim and edge in the same cycle ----
    src[0] = 1'b1; step(); src[0] = 1'b0; step();
    src[0] = 1'b1; re = 1'b1; addr = CLAIM;
    step();
    re = 1'b0; src[0] = 1'b0;
    check_eq("same_cycle_claim", rdata, 32'd1);
    rd(PENDING, d);          check_eq("same_cycle_pend", d, 32'h01);

    // ---- randomized phase ----
    apply_reset();
    repeat (700) begin
      for (int s = 0; s < NS; s++)
        if ($urandom_range(0, 7) == 0) src[s] = ~src[s];
      we = 1'b0; re = 1'b0;
      case ($urandom_range(0, 9))
        0, 1: begin we = 1'b1; addr = rand_addr(); wdata = $urandom(); end
        2, 3: begin re = 1'b1; addr = CLAIM; end
        4:    begin re = 1'b1; addr = rand_addr(); end
        5, 6: begin we = 1'b1; addr = CLAIM; wdata = 32'($urandom_range(0, 10)); end
        7:    begin we = 1'b1; re = 1'b1; addr = rand_addr(); wdata = $urandom(); end
        default: ;
      endcase
      if (we && addr == THRESH) wdata = 32'($urandom_range(0, 2));
      step();
    end
    we = 1'b0; re = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
